ncl_freq_meter: RTL

Synchronous frequency meter for the NCL ring experiments. Consumes the ring's divided-down completion signal (already prescaled by the async divider chain), synchronises it into the 25 MHz board clock domain and counts its rising edges over a fixed gate window. Each window produces a latched count, a valid strobe, a peak-hold value and stall/overflow flags, which drive the LEDs and the logic-analyser pins.

---
 rtl/ncl_pkg.sv | 19 +
 rtl/ncl_sync_edge.sv | 41 ++++
 rtl/ncl_freq_meter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ncl_pkg.sv
// -----------------------------------------------------------------------------
// ncl_pkg
//   Shared definitions for the NCL ring measurement blocks.
//   - meter_state_t : frequency-meter control states
//   - SETTLE_CYCLES : cycles spent flushing the synchroniser before a gate
//   - SYNC_STAGES   : flops in the metastability synchroniser chain
// -----------------------------------------------------------------------------
package ncl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2
    } meter_state_t;

    localparam int SETTLE_CYCLES = 3;
    localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/ncl_sync_edge.sv
// -----------------------------------------------------------------------------
// ncl_sync_edge
//   Brings an asynchronous level into the clk domain through a STAGES-deep
//   flop chain and flags each rising transition with a one-cycle pulse.
//   Reusable for any slow asynchronous probe (phases >= 2 clock periods).
//
// Ports
//   clk      : sampling clock
//   rst_n    : asynchronous active-low reset, clears the whole chain
//   async_in : asynchronous input level
//   rise     : one-cycle pulse, high on the cycle after the synchronised
//              level goes 0 -> 1
// -----------------------------------------------------------------------------
module ncl_sync_edge
    import ncl_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
)(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    // sync_q[0] is the only flop that ever sees async_in directly.
    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/ncl_freq_meter.sv
// -----------------------------------------------------------------------------
// ncl_freq_meter
//   Counts rising edges of the prescaled NCL ring signal over a fixed gate
//   window of GATE_CYCLES board-clock cycles. Windows run back to back while
//   go is high; each completed window latches a count, pulses count_valid and
//   updates the peak-hold and stall/overflow flags.
//   Ring frequency = count_q * PRESCALE * 25e6 / GATE_CYCLES.
//
// Ports
//   clk_25mhz   : board clock, only clock of the block
//   rst_n       : asynchronous active-low reset
//   go          : measurement enable (synchronous)
//   async_tick  : prescaled ring signal (asynchronous)
//   count_q     : edge count of the last completed window
//   count_valid : one-cycle strobe when count_q updates
//   peak_q      : largest count_q since the last measurement start
//   stalled     : last window saw no edges
//   overflow    : last window's count saturated
//   led         : most significant 8 bits of count_q (zero-padded below
//                 when COUNT_W < 8)
// -----------------------------------------------------------------------------
module ncl_freq_meter
    import ncl_pkg::*;
#(
    parameter int GATE_CYCLES = 25_000_000,
    parameter int COUNT_W     = 24,
    parameter int PRESCALE    = 128
)(
    input  logic               clk_25mhz,
    input  logic               rst_n,
    input  logic               go,
    input  logic               async_tick,
    output logic [COUNT_W-1:0] count_q,
    output logic               count_valid,
    output logic [COUNT_W-1:0] peak_q,
    output logic               stalled,
    output logic               overflow,
    output logic [7:0]         led
);

    localparam int                 GATE_W      = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]  GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
    localparam int                 SETTLE_W    = $clog2(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX   = '1;

    // Parameter sanity: a gate shorter than 4 cycles cannot hold a window,
    // and a zero prescale makes the reported frequency meaningless.
    if (GATE_CYCLES < 4 || PRESCALE < 1) begin : g_bad_param
        $error("ncl_freq_meter: GATE_CYCLES must be >= 4 and PRESCALE >= 1");
    end

    // Saturating increment of the edge counter.
    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] value,
        input logic               inc
    );
        if (inc && value != COUNT_MAX) begin
            return value + COUNT_W'(1);
        end
        return value;
    endfunction

    // -------------------------------------------------------------------------
    // Edge source
    // -------------------------------------------------------------------------
    logic tick_rise;

    ncl_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk_25mhz),
        .rst_n    (rst_n),
        .async_in (async_tick),
        .rise     (tick_rise)
    );

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    meter_state_t        state;
    meter_state_t        state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [GATE_W-1:0]   gate_cnt;
    logic [COUNT_W-1:0]  edge_cnt;
    logic                sat;

    logic                counting;   // this cycle belongs to a live window
    logic                win_end;    // this cycle is the terminal gate cycle
    logic                peak_clr;   // measurement is (re)starting

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // go is checked before anything else in SETTLE and GATE so that
    // dropping it always abandons the window, even on its terminal cycle.
    always_comb begin
        state_nxt = state;
        counting  = 1'b0;
        win_end   = 1'b0;
        peak_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = SETTLE;
                    peak_clr  = 1'b1;
                end
            end
            SETTLE: begin
                if (!go) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = GATE;
                end
            end
            GATE: begin
                if (!go) begin
                    state_nxt = IDLE;
                end else begin
                    counting = 1'b1;
                    win_end  = (gate_cnt == GATE_LAST);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Window counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
        end else begin
            // Holds zero outside SETTLE, so every SETTLE entry starts at 0.
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end else begin
                settle_cnt <= '0;
            end

            // The terminal cycle clears rather than advances, so the next
            // window starts on the very next cycle with no dead time.
            if (!counting || win_end) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                edge_cnt <= sat_inc(edge_cnt, tick_rise);
                sat      <= sat | (tick_rise && edge_cnt == COUNT_MAX);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result registers
    // -------------------------------------------------------------------------
    // The edge arriving on the terminal cycle still belongs to the ending
    // window, so it is folded into the latched result here.
    logic [COUNT_W-1:0] result;
    logic               result_ovf;

    assign result     = sat_inc(edge_cnt, tick_rise);
    assign result_ovf = sat | (tick_rise && edge_cnt == COUNT_MAX);

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            count_valid <= 1'b0;
            peak_q      <= '0;
            stalled     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            count_valid <= win_end;
            if (peak_clr) begin
                peak_q <= '0;
            end
            if (win_end) begin
                count_q  <= result;
                overflow <= result_ovf;
                stalled  <= (result == '0);
                if (result > peak_q) begin
                    peak_q <= result;
                end
            end
        end
    end

    if (COUNT_W >= 8) begin : g_led_top
        assign led = count_q[COUNT_W-1 -: 8];
    end else begin : g_led_pad
        assign led = {count_q, {(8 - COUNT_W){1'b0}}};
    end

endmodule
